data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the core's data port. Services load/store requests issued by the `cpu` over the `dataAddr`/`writeData`/`we`/`readData` interface.
- Adds a `req`/`ready` handshake with configurable wait states.
- Performs RV32I byte/halfword/word lane selection and sign/zero extension, keyed on the instruction's `funct3`.
- Flags misaligned, out-of-range and illegal accesses via `err`. Sits between the core and the on-chip data RAM.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words. Byte address range is 0 to 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 1: extra cycles between accept and response. Legal range 0..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  access size/sign (RV32I load/store `funct3` encoding).
- dataAddr  in  32  byte address.
- writeData  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- ready  out  1  one-cycle response strobe.
- readData  out  32  formatted load data; valid only while ready=1.
- err  out  1  access error; valid only while ready=1.
- busy  out  1  high in WAIT and RESP.

Behaviour:
- Reset:
  - state=IDLE, wait counter=0, ready=0, err=0, readData=0, busy=0.
  - RAM contents are not affected by reset.
  - Reset during WAIT or RESP aborts the transaction: no ready pulse, pending store discarded.
- FSM states IDLE, WAIT, RESP:
  - IDLE, req=1 at edge N: latch we, funct3, dataAddr, writeData; counter=WAIT_CYCLES; go to WAIT, or to RESP if WAIT_CYCLES=0.
  - WAIT: decrement counter each cycle; go to RESP on the edge where counter reaches 0 (counter==1 before that edge).
  - RESP: ready=1 for exactly one cycle, then IDLE.
- Latency and throughput:
  - ready is high in cycle N+1+WAIT_CYCLES.
  - Next accept is no earlier than the cycle after RESP, so max throughput is one transaction per WAIT_CYCLES+2 cycles.
  - req outside IDLE is ignored; inputs may change freely after accept.
- Store commit: the RAM write happens on the edge that ends RESP. A following transaction observes it. Ordering is little-endian.
- Store lane rules:
  - SB (000): byte lane dataAddr[1:0] gets writeData[7:0].
  - SH (001): halfword lane dataAddr[1] gets writeData[15:0].
  - SW (010): full word. Unwritten lanes are preserved.
- Load formatting:
  - LB (000): selected byte, sign-extended.
  - LH (001): selected halfword, sign-extended.
  - LW (010): full word.
  - LBU (100): selected byte, zero-extended.
  - LHU (101): selected halfword, zero-extended.
- Error conditions (checked on latched values):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - dataAddr >= 4*DEPTH_WORDS, with no wrap or aliasing.
  - Load funct3 in {011,110,111}.
  - Store funct3 not in {000,001,010}.
- On error: err=1 and readData=0 in RESP, no RAM write, timing identical to a good access.
- Outside RESP: ready=0, err=0, readData=0.
- The word index is dataAddr[ceil(log2 DEPTH_WORDS)+1:2] after the range check passes.

Test Plan:
(WAIT_CYCLES=2 and DEPTH_WORDS=1024 unless stated.)
- Basic store/load:
  - SW addr 0x10, data 0xDEADBEEF accepted at cycle 0 -> ready=1, err=0 in cycle 3 only; busy high in cycles 1-3.
  - Then LW 0x10 -> readData=0xDEADBEEF.
- Load formatting (continuing from above):
  - LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x10 -> 0x0000BEEF.
  - LB 0x10 -> 0xFFFFFFEF.
- Partial stores:
  - SB 0x11, data 0x12345677 -> LW 0x10 = 0xDEAD77EF.
  - SH 0x12, data 0xAAAA5555 -> LW 0x10 = 0x555577EF.
- Errors (each returns err=1, readData=0 on the normal ready cycle):
  - LW 0x12.
  - SH 0x21, data 0xFFFF; afterwards LW 0x20 is unchanged.
  - LW 0x1000 (out of range).
  - Load funct3=011.
- Reset mid-transaction:
  - SW 0x20, data 0x00000000 completes.
  - SW 0x20, data 0x11111111, with reset high for 1 cycle during WAIT -> no ready pulse; all outputs 0 the cycle after reset.
  - LW 0x20 -> 0x00000000.
- Throughput:
  - req held high with alternating SW/LW -> ready pulses every 4 cycles.
  - WAIT_CYCLES=0 build: ready the cycle after accept; back-to-back pulses every 2 cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store responder for the core data port.
// Accepts one request in IDLE, waits WAIT_CYCLES, then returns a single-cycle
// ready strobe with RV32I-formatted load data or an error flag. A good store
// is committed on the edge that ends the response cycle.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] dataAddr,
  input  logic [31:0] writeData,
  output logic        ready,
  output logic [31:0] readData,
  output logic        err,
  output logic        busy
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          access_err;
  logic [AW-1:0] idx;
  logic [31:0]   word_rd;
  logic [31:0]   word_wr;
  logic [31:0]   load_fmt;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          mem_we;

  // Next-state logic: latch the request in IDLE, count down in WAIT, one RESP cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d     = we;
          funct3_d = funct3;
          addr_d   = dataAddr;
          wdata_d  = writeData;
          cnt_d    = WAIT_INIT;
          state_d  = (WAIT_INIT == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Error decode on the latched request: range, alignment and funct3 legality.
  always_comb begin
    access_err = 1'b0;
    if (addr_q >= BYTE_LIMIT) access_err = 1'b1;
    if (we_q) begin
      case (funct3_q)
        3'b000:  ;
        3'b001:  if (addr_q[0]) access_err = 1'b1;
        3'b010:  if (addr_q[1:0] != 2'b00) access_err = 1'b1;
        default: access_err = 1'b1;
      endcase
    end else begin
      case (funct3_q)
        3'b000, 3'b100: ;
        3'b001, 3'b101: if (addr_q[0]) access_err = 1'b1;
        3'b010:         if (addr_q[1:0] != 2'b00) access_err = 1'b1;
        default:        access_err = 1'b1;
      endcase
    end
  end

  assign idx     = addr_q[AW+1:2];
  assign word_rd = mem[idx];

  // Load lane selection and sign/zero extension.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = word_rd[7:0];
      2'd1:    byte_sel = word_rd[15:8];
      2'd2:    byte_sel = word_rd[23:16];
      default: byte_sel = word_rd[31:24];
    endcase
    half_sel = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
    case (funct3_q)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_fmt = {24'd0, byte_sel};
      3'b101:  load_fmt = {16'd0, half_sel};
      default: load_fmt = word_rd;
    endcase
  end

  // Store merge: replace only the addressed lanes, keep the rest of the word.
  always_comb begin
    word_wr = word_rd;
    case (funct3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    word_wr[7:0]   = wdata_q[7:0];
          2'd1:    word_wr[15:8]  = wdata_q[7:0];
          2'd2:    word_wr[23:16] = wdata_q[7:0];
          default: word_wr[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) word_wr[31:16] = wdata_q[15:0];
        else           word_wr[15:0]  = wdata_q[15:0];
      end
      default: word_wr = wdata_q;
    endcase
  end

  // A reset coinciding with the end of RESP discards the pending store.
  assign mem_we = (state_q == S_RESP) && we_q && !access_err && !reset;

  // RAM write port; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= word_wr;
  end

  assign ready    = (state_q == S_RESP);
  assign err      = ready && access_err;
  assign readData = (ready && !access_err && !we_q) ? load_fmt : 32'd0;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: WAIT_CYCLES=2 main instance plus a
// WAIT_CYCLES=0 instance for the zero-wait latency and throughput cases.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] dataAddr = 32'd0, writeData = 32'd0;
  logic        ready, err, busy;
  logic [31:0] readData;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [2:0]  funct30 = 3'd0;
  logic [31:0] dataAddr0 = 32'd0, writeData0 = 32'd0;
  logic        ready0, err0, busy0;
  logic [31:0] readData0;

  int n_total = 0;
  int n_pass  = 0;

  int          t_lat;
  logic [31:0] t_rd;
  logic        t_err;
  logic        t_busy;
  logic [1:0]  t_after;

  int pos [4];
  int npulse;
  int nready;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
    .dataAddr(dataAddr), .writeData(writeData),
    .ready(ready), .readData(readData), .err(err), .busy(busy)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .funct3(funct30),
    .dataAddr(dataAddr0), .writeData(writeData0),
    .ready(ready0), .readData(readData0), .err(err0), .busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One transaction on the main instance; inputs are scrambled right after accept.
  task automatic txn(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f; dataAddr = a; writeData = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; funct3 = 3'b111; dataAddr = 32'hFFFF_FFFF; writeData = ~d;
    t_lat = 0; t_rd = 32'd0; t_err = 1'b0; t_busy = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      t_busy &= busy;
      if (ready) begin
        t_lat = i; t_rd = readData; t_err = err;
        break;
      end
    end
    @(negedge clk);
    t_after = {ready, busy};
  endtask

  task automatic chk_txn(input string tag, input logic [31:0] exp_rd, input logic exp_err);
    chk({tag, "_lat"},   t_lat,   32'd3);
    chk({tag, "_rd"},    t_rd,    exp_rd);
    chk({tag, "_err"},   t_err,   exp_err);
    chk({tag, "_busy"},  t_busy,  1'b1);
    chk({tag, "_after"}, t_after, 2'b00);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", readData, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst0_ready_busy", {ready0, busy0}, 2'b00);

    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);  chk_txn("sw_10", 32'd0, 1'b0);
    txn(1'b0, 3'b010, 32'h10, 32'd0);          chk_txn("lw_10", 32'hDEADBEEF, 1'b0);
    txn(1'b0, 3'b000, 32'h13, 32'd0);          chk_txn("lb_13", 32'hFFFFFFDE, 1'b0);
    txn(1'b0, 3'b100, 32'h13, 32'd0);          chk_txn("lbu_13", 32'h000000DE, 1'b0);
    txn(1'b0, 3'b001, 32'h12, 32'd0);          chk_txn("lh_12", 32'hFFFFDEAD, 1'b0);
    txn(1'b0, 3'b101, 32'h10, 32'd0);          chk_txn("lhu_10", 32'h0000BEEF, 1'b0);
    txn(1'b0, 3'b000, 32'h10, 32'd0);          chk_txn("lb_10", 32'hFFFFFFEF, 1'b0);

    txn(1'b1, 3'b000, 32'h11, 32'h12345677);  chk_txn("sb_11", 32'd0, 1'b0);
    txn(1'b0, 3'b010, 32'h10, 32'd0);          chk_txn("lw_after_sb", 32'hDEAD77EF, 1'b0);
    txn(1'b1, 3'b001, 32'h12, 32'hAAAA5555);  chk_txn("sh_12", 32'd0, 1'b0);
    txn(1'b0, 3'b010, 32'h10, 32'd0);          chk_txn("lw_after_sh", 32'h555577EF, 1'b0);

    txn(1'b0, 3'b010, 32'h12, 32'd0);          chk_txn("err_lw_misalign", 32'd0, 1'b1);
    txn(1'b1, 3'b010, 32'h20, 32'h00000000);  chk_txn("sw_20", 32'd0, 1'b0);
    txn(1'b1, 3'b001, 32'h21, 32'h0000FFFF);  chk_txn("err_sh_misalign", 32'd0, 1'b1);
    txn(1'b1, 3'b011, 32'h20, 32'hFFFFFFFF);  chk_txn("err_st_f3", 32'd0, 1'b1);
    txn(1'b0, 3'b010, 32'h20, 32'd0);          chk_txn("lw_20_kept", 32'h00000000, 1'b0);
    txn(1'b0, 3'b010, 32'h1000, 32'd0);        chk_txn("err_lw_range", 32'd0, 1'b1);
    txn(1'b0, 3'b011, 32'h10, 32'd0);          chk_txn("err_ld_f3", 32'd0, 1'b1);

    txn(1'b1, 3'b010, 32'hFFC, 32'h13579BDF); chk_txn("sw_top", 32'd0, 1'b0);
    txn(1'b0, 3'b010, 32'hFFC, 32'd0);         chk_txn("lw_top", 32'h13579BDF, 1'b0);
    txn(1'b0, 3'b000, 32'hFFF, 32'd0);         chk_txn("lb_top", 32'h00000013, 1'b0);

    // Reset pulse during WAIT aborts the store.
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; dataAddr = 32'h20; writeData = 32'h11111111;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("abort_busy_wait", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_outs", {ready, err, busy, readData}, 35'd0);
    nready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ready) nready++;
    end
    chk("abort_no_ready", nready, 32'd0);
    txn(1'b0, 3'b010, 32'h20, 32'd0);          chk_txn("lw_20_after_abort", 32'h00000000, 1'b0);

    // Held req with alternating SW/LW: pulse every WAIT_CYCLES+2 cycles.
    for (int k = 0; k < 4; k++) pos[k] = -100;
    npulse = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; dataAddr = 32'h10; writeData = 32'h555577EF;
    for (int c = 0; c < 40 && npulse < 4; c++) begin
      @(negedge clk);
      if (ready) begin
        pos[npulse] = c;
        if (!we) chk("tput_rd", readData, 32'h555577EF);
        npulse++;
        we = ~we;
        if (npulse == 4) req = 1'b0;
      end
    end
    req = 1'b0;
    chk("tput_npulse", npulse, 32'd4);
    chk("tput_gap1", pos[1] - pos[0], 32'd4);
    chk("tput_gap2", pos[2] - pos[1], 32'd4);
    chk("tput_gap3", pos[3] - pos[2], 32'd4);

    // Zero-wait instance: ready the cycle after accept, then 2-cycle cadence.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; funct30 = 3'b010; dataAddr0 = 32'h4; writeData0 = 32'hCAFEF00D;
    @(posedge clk);
    #1 req0 = 1'b0; we0 = 1'b0; dataAddr0 = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("w0_sw_ready", {ready0, err0, busy0}, 3'b101);
    @(negedge clk);
    chk("w0_sw_after", {ready0, busy0}, 2'b00);

    for (int k = 0; k < 4; k++) pos[k] = -100;
    npulse = 0;
    req0 = 1'b1; we0 = 1'b0; funct30 = 3'b010; dataAddr0 = 32'h4;
    for (int c = 0; c < 20 && npulse < 4; c++) begin
      @(negedge clk);
      if (ready0) begin
        pos[npulse] = c;
        if (npulse == 0) chk("w0_lw_rd", readData0, 32'hCAFEF00D);
        npulse++;
        if (npulse == 4) req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    chk("w0_npulse", npulse, 32'd4);
    chk("w0_first_lat", pos[0], 32'd0);
    chk("w0_gap1", pos[1] - pos[0], 32'd2);
    chk("w0_gap3", pos[3] - pos[2], 32'd2);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
